// File: rtl/wave_seq_pkg.sv
// Purpose : shared types and constants for the wave sequencer slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t {ST_IDLE, ST_RUN, ST_DONE}, default widths, HALF = 2^(DATA_W-1).
package wave_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;
  localparam int HALF       = 2 ** (DATA_W_DEF - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wave_fold.sv
// Purpose : folds a phase ramp into a triangle (phase up to HALF, then 2^DATA_W - phase).
// Latency : purely combinational, zero cycles.
// Backpressure: none; output follows input every cycle.
// Ports   : i_phase (DATA_W) phase in; o_wave (DATA_W) folded sample out.
module wave_fold
  import wave_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] i_phase,
  output logic [DATA_W-1:0] o_wave
);

  // Package HALF is for the default width; other widths derive their own midpoint.
  localparam int              W_HALF   = (DATA_W == DATA_W_DEF) ? HALF : 2 ** (DATA_W - 1);
  localparam logic [DATA_W:0] W_HALF_V = (DATA_W + 1)'(W_HALF);

  logic [DATA_W-1:0] w_neg;

  // 2^DATA_W - phase is just the two's-complement negation modulo 2^DATA_W.
  assign w_neg  = '0 - i_phase;
  assign o_wave = ({1'b0, i_phase} <= W_HALF_V) ? i_phase : w_neg;

endmodule

// File: rtl/wave_seq_ctrl.sv
// Purpose : command-driven burst sequencer producing a phase ramp at a programmable tick rate.
// Latency : first sample_en cmd_div+1 clocks after accept; wave_out follows phase with no extra delay.
// Backpressure: cmd_ready only in IDLE; pause freezes the burst, abort ends it without done.
// Ports   : clk, rst (sync active-low); cmd_valid/cmd_ready/cmd_step/cmd_div/cmd_cycles command;
//           pause, abort controls; phase, wave_out, sample_en, busy, done status.
// Option  : define WAVE_SEQ_FOLD_EN for a triangle fold on wave_out; otherwise wave_out = phase.
module wave_seq_ctrl
  import wave_seq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_step,
  input  logic [CNT_W-1:0]  cmd_div,
  input  logic [CNT_W-1:0]  cmd_cycles,
  input  logic              pause,
  input  logic              abort,
  output logic [DATA_W-1:0] phase,
  output logic [DATA_W-1:0] wave_out,
  output logic              sample_en,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [DATA_W-1:0] r_phase;
  logic [DATA_W-1:0] r_step;
  logic [CNT_W-1:0]  r_div;
  logic [CNT_W-1:0]  r_div_cnt;
  logic [CNT_W-1:0]  r_cycles_left;
  logic              r_sample_en;
  logic              r_busy;
  logic              r_done;

  // Extra top bit is the wrap flag: one full period completed on this tick.
  logic [DATA_W:0]   w_sum;

  assign w_sum     = {1'b0, r_phase} + {1'b0, r_step};
  assign cmd_ready = (r_state == ST_IDLE);
  assign phase     = r_phase;
  assign sample_en = r_sample_en;
  assign busy      = r_busy;
  assign done      = r_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_phase       <= '0;
      r_step        <= '0;
      r_div         <= '0;
      r_div_cnt     <= '0;
      r_cycles_left <= '0;
      r_sample_en   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_sample_en <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_step        <= (cmd_step == '0) ? DATA_W'(1) : cmd_step;
            r_div         <= cmd_div;
            r_div_cnt     <= cmd_div;
            r_cycles_left <= cmd_cycles;
            r_phase       <= '0;
            r_busy        <= 1'b1;
            r_state       <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_phase <= '0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (pause) begin
            // Everything holds; a wrap that would land here is simply deferred.
          end else if (r_div_cnt != '0) begin
            r_div_cnt <= r_div_cnt - CNT_W'(1);
          end else begin
            r_phase     <= w_sum[DATA_W-1:0];
            r_div_cnt   <= r_div;
            r_sample_en <= 1'b1;
            // cycles_left == 0 means continuous: wraps are not counted.
            if (w_sum[DATA_W] && (r_cycles_left != '0)) begin
              if (r_cycles_left == CNT_W'(1)) begin
                r_phase <= '0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= ST_DONE;
              end else begin
                r_cycles_left <= r_cycles_left - CNT_W'(1);
              end
            end
          end
        end
        default: begin
          // DONE: single cycle with done high, then back to IDLE.
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WAVE_SEQ_FOLD_EN
  wave_fold #(
    .DATA_W (DATA_W)
  ) u_fold (
    .i_phase (r_phase),
    .o_wave  (wave_out)
  );
`else
  assign wave_out = r_phase;
`endif

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Purpose : self-checking bench for wave_seq_ctrl against a tick-count reference model.
// Latency : n/a.
// Backpressure: n/a.
module tb_wave_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] cmd_step = '0;
  logic [7:0] cmd_div = '0;
  logic [7:0] cmd_cycles = '0;
  logic       cmd_ready, sample_en, busy, done;
  logic [7:0] phase, wave_out;
  logic [19:0] obs;

  int errors = 0;
  int checks = 0;

  // Reference model: mode 0 idle, 1 run, 2 done. Position in a burst is the number of
  // un-paused RUN clocks since accept; tick n lands at n*(div+1) and phase is n*step mod 256.
  int m_mode = 0;
  int m_step = 0, m_div = 0, m_cycles = 0, m_act = 0, m_phase = 0;
  bit m_sen = 0, m_busy = 0, m_done = 0;

  wave_seq_ctrl #(.DATA_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_step   (cmd_step),
    .cmd_div    (cmd_div),
    .cmd_cycles (cmd_cycles),
    .pause      (pause),
    .abort      (abort),
    .phase      (phase),
    .wave_out   (wave_out),
    .sample_en  (sample_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  assign obs = {phase, wave_out, sample_en, busy, done, cmd_ready};

  function automatic int exp_wave(int p);
`ifdef WAVE_SEQ_FOLD_EN
    return (p <= 128) ? p : 256 - p;
`else
    return p;
`endif
  endfunction

  function automatic logic [19:0] exp_vec();
    return {8'(m_phase), 8'(exp_wave(m_phase)), m_sen, m_busy, m_done, (m_mode == 0)};
  endfunction

  task automatic model_edge();
    int total;
    if (!rst) begin
      m_mode = 0; m_phase = 0; m_sen = 0; m_busy = 0; m_done = 0;
      m_step = 0; m_div = 0; m_cycles = 0; m_act = 0;
    end else begin
      m_sen = 0;
      m_done = 0;
      case (m_mode)
        0: if (cmd_valid) begin
          m_step = (cmd_step == 0) ? 1 : int'(cmd_step);
          m_div = int'(cmd_div);
          m_cycles = int'(cmd_cycles);
          m_act = 0; m_phase = 0; m_mode = 1; m_busy = 1;
        end
        1: if (abort) begin
          m_mode = 0; m_phase = 0; m_busy = 0;
        end else if (!pause) begin
          m_act++;
          if (m_act % (m_div + 1) == 0) begin
            total = (m_act / (m_div + 1)) * m_step;
            m_sen = 1;
            if (m_cycles != 0 && total / 256 >= m_cycles) begin
              m_mode = 2; m_phase = 0; m_busy = 0; m_done = 1;
            end else begin
              m_phase = total % 256;
            end
          end
        end
        default: m_mode = 0;
      endcase
    end
  endtask

  // Advance one clock; inputs are only changed after the #1, away from the edge.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_cmd(input int s, input int d, input int c);
    cmd_step = 8'(s); cmd_div = 8'(d); cmd_cycles = 8'(c);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 20'h00001) begin
        errors++;
        $display("FAIL reset_init[%0d]: got %h expected %h", i, obs, 20'h00001);
      end
    end
    rst = 1'b1;
    send_cmd(37, 0, 0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    abort = 1'b1; pause = 1'b1; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 20'h00001 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL reset_midrun[%0d]: got %h expected %h", i, obs, 20'h00001);
      end
    end
    rst = 1'b1; abort = 1'b0; pause = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic test_burst_count();
    int strobes = 0, dones = 0;
    int seq [8] = '{64, 128, 192, 0, 64, 128, 192, 0};
    send_cmd(64, 0, 2);
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL burst cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      if (sample_en) begin
        checks++;
        if (strobes < 8 && phase !== 8'(seq[strobes])) begin
          errors++;
          $display("FAIL burst_phase[%0d]: got %0d expected %0d", strobes, phase, seq[strobes]);
        end
        strobes++;
      end
      if (done) dones++;
      tick();
    end
    checks++;
    if (strobes !== 8) begin
      errors++;
      $display("FAIL burst_strobes: got %0d expected 8", strobes);
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL burst_done_count: got %0d expected 1", dones);
    end
  endtask

  task automatic test_continuous_abort();
    int first = -1, ticks = 0, dones = 0;
    send_cmd(1, 3, 0);
    for (int i = 1; i <= 1300; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL cont cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      if (sample_en) begin
        if (first < 0) first = i;
        ticks++;
      end
      if (done) dones++;
    end
    checks++;
    if (first !== 4) begin
      errors++;
      $display("FAIL cont_first_tick: got %0d expected 4", first);
    end
    checks++;
    if (ticks !== 325) begin
      errors++;
      $display("FAIL cont_tick_count: got %0d expected 325", ticks);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (done) dones++;
    checks++;
    if (obs !== 20'h00001 || obs !== exp_vec()) begin
      errors++;
      $display("FAIL cont_abort: got %h expected %h", obs, 20'h00001);
    end
    tick();
    if (done) dones++;
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL cont_no_done: got %0d expected 0", dones);
    end
  endtask

  task automatic test_pause();
    logic [7:0] held;
    send_cmd(16, 1, 0);
    for (int i = 0; i < 5; i++) tick();
    held = phase;
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (phase !== held || sample_en !== 1'b0 || obs !== exp_vec()) begin
        errors++;
        $display("FAIL pause_hold[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    pause = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL pause_resume[%0d]: got %h expected %h", i, obs, exp_vec());
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_ignore_cmd();
    int done_at = -1;
    send_cmd(0, 0, 1);
    cmd_valid = 1'b1; cmd_step = 8'd77; cmd_div = 8'd5; cmd_cycles = 8'd3;
    for (int i = 1; i <= 300 && done_at < 0; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ignore cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
      if (done) done_at = i;
    end
    checks++;
    if (done_at !== 256) begin
      errors++;
      $display("FAIL ignore_done_at: got %0d expected 256", done_at);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL ignore_next cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_new_accept: busy got %b expected 1", busy);
    end
    cmd_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_wave();
    int ew;
    send_cmd(8, 0, 1);
    for (int k = 1; k <= 32; k++) begin
      tick();
`ifdef WAVE_SEQ_FOLD_EN
      ew = (k == 32) ? 0 : ((k <= 16) ? 8 * k : 256 - 8 * k);
`else
      ew = int'(phase);
`endif
      checks++;
      if (wave_out !== 8'(ew) || obs !== exp_vec()) begin
        errors++;
        $display("FAIL wave k%0d: wave %0d phase %0d expected wave %0d", k, wave_out, phase, ew);
      end
    end
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      pause = ($urandom_range(0, 4) == 0);
      abort = ($urandom_range(0, 79) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      cmd_step = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      cmd_div = 8'($urandom_range(0, 2));
      cmd_cycles = 8'($urandom_range(0, 3));
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc%0d: got %h expected %h", i, obs, exp_vec());
      end
    end
    rst = 1'b1; pause = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_burst_count();
    test_continuous_abort();
    test_pause();
    test_ignore_cmd();
    test_wave();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wave_seq_ctrl.md
Name: wave_seq_ctrl

Overview:
- Command-driven sequencer for the lab's 8-bit triangle-wave datapath.
- Accepts a burst command through a valid/ready handshake, then generates the phase ramp at a programmable rate.
- Counts completed waveform periods and reports completion.
- Sits between the host/test logic and the DAC-side waveform output; it replaces free-running counters with a controlled, abortable, pausable burst.

Parameters:
- DATA_W, 8: phase/wave width; all arithmetic is modulo 2^DATA_W.
- CNT_W, 8: width of the period-count and divider fields.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a clk edge resets).
- cmd_valid  in  1  host presents a command.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid&&cmd_ready.
- cmd_step  in  DATA_W  phase increment per tick; 0 is treated as 1.
- cmd_div  in  CNT_W  tick every cmd_div+1 clocks.
- cmd_cycles  in  CNT_W  periods to generate; 0 means continuous.
- pause  in  1  level; freezes the sequence while high (RUN only).
- abort  in  1  pulse/level; ends any burst.
- phase  out  DATA_W  current phase (registered).
- wave_out  out  DATA_W  waveform sample (see Optional Feature).
- sample_en  out  1  one-clock strobe; phase/wave_out changed this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-clock pulse when a burst ends by count (not by abort).

Behaviour:
- Reset values: state=IDLE, phase=0, wave_out=0, sample_en=0, busy=0, done=0, cmd_ready=1 (combinational from IDLE); internal div_cnt, cycles_left, step_r, div_r are all 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On accept at edge t: latch step_r (0 becomes 1), div_r, cycles_left=cmd_cycles; set div_cnt=cmd_div, phase=0.
  - Enter RUN; busy=1 from t+1.
- RUN, checked in this priority order each edge:
  1. abort=1: go to IDLE; phase=0, wave_out=0, sample_en=0, no done pulse.
  2. pause=1: hold div_cnt, phase and cycles_left; sample_en=0.
  3. div_cnt!=0: decrement div_cnt; sample_en=0.
  4. div_cnt==0 (tick): compute sum = phase + step_r (DATA_W+1 bits); set phase=sum[DATA_W-1:0], div_cnt=div_r, sample_en=1.
     - If sum[DATA_W]==1 (wrap, i.e. one period complete) and cycles_left!=0:
       - cycles_left==1: go to DONE and force phase=0.
       - otherwise: decrement cycles_left.
     - If cycles_left==0 (continuous): wraps are ignored.
- Tick timing: the first tick falls div_r+1 clocks after accept. Example: div=0 gives a tick every clock, first sample_en at t+1.
- DONE: lasts one cycle; done=1, busy=0, cmd_ready=0, then IDLE. abort in DONE has no extra effect.
- cmd_valid outside IDLE is ignored, with no side effects.
- wave_out updates on the same edge as phase, with zero added latency.
- Reset mid-burst: immediate return to reset values at that edge; reset dominates abort, pause and the command.
- Simultaneous wrap and pause: pause wins, so no tick occurs and no count is consumed.

Optional Feature:
- Macro: WAVE_SEQ_FOLD_EN.
- Defined: wave_out = phase when phase <= 2^(DATA_W-1); otherwise wave_out = 2^DATA_W − phase (triangle fold; for 8 bits, 200 maps to 56).
- Undefined: wave_out = phase (sawtooth); the fold logic is absent.

Decomposition:
- Package wave_seq_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - DATA_W/CNT_W defaults
  - HALF = 2^(DATA_W-1)
- Sub-module wave_fold: purely combinational phase→wave_out fold, instantiated only under WAVE_SEQ_FOLD_EN.

Test Plan:
- Reset: hold rst=0 for 3 clocks during RUN → phase=0, busy=0, cmd_ready=1, sample_en=0 on the first edge.
- Step=64, div=0, cycles=2 → phase sequence 64,128,192,0,64,128,192, then DONE with phase=0 and a done pulse exactly once; 8 sample_en strobes total.
- Step=1, div=3, cycles=0 → sample_en every 4th clock, first one 4 clocks after accept; runs past 300 ticks; abort → IDLE next edge, done never asserted.
- Pause held for 10 clocks mid-RUN (step=16, div=1) → phase and sample_en frozen; the sequence resumes with the same div_cnt value.
- cmd_valid held high during RUN with different fields → ignored; after done, the new command is accepted in IDLE; cmd_step=0 behaves as step 1.
- With WAVE_SEQ_FOLD_EN, step=8 → wave_out rises 8..128 then falls 120..8, 0; without the macro, wave_out == phase every cycle.
